mem_arbiter_rr: RTL

Parametrised round-robin arbiter that shares one single-port synchronous RAM among NCORES processor cores. It succeeds the fixed 4-core byte-lane memory controller and adds the following:
- per-core request/grant handshake
- fair rotation with a burst cap
- single-cycle write strobes
- per-core read-data-valid that tracks RAM read latency

It sits between the core array and the shared data RAM.

---
 rtl/mem_arbiter_rr_if.sv | 31 +++
 rtl/mem_arbiter_rr.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr_if.sv
// Core-array and RAM-side signal bundle for mem_arbiter_rr.
// master = cores plus RAM model, slave = the arbiter.
interface mem_arbiter_rr_if #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
);
    logic [NCORES-1:0]    req;
    logic [NCORES-1:0]    wr;
    logic [NCORES*AW-1:0] addr;
    logic [NCORES*DW-1:0] wdata;
    logic [NCORES-1:0]    gnt;
    logic [NCORES-1:0]    rvalid;
    logic [DW-1:0]        rdata;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_din;
    logic                 ram_wren;
    logic [DW-1:0]        ram_q;

    modport master (
        output req, wr, addr, wdata, ram_q,
        input  gnt, rvalid, rdata,
        input  ram_addr, ram_din, ram_wren
    );

    modport slave (
        input  req, wr, addr, wdata, ram_q,
        output gnt, rvalid, rdata,
        output ram_addr, ram_din, ram_wren
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one synchronous RAM among NCORES cores,
// with a per-owner burst cap and read-valid tags matching RAM latency.
module mem_arbiter_rr #(
    parameter int NCORES    = 4,
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_rr_if.slave bus
);
    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     owner, owner_nx;
    logic [IW-1:0]     ptr, ptr_nx;
    logic [IW-1:0]     succ;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [IW:0]       hit_idle, hit_rot;
    logic              acc, rot;
    logic [NCORES-1:0] gnt, gnt_nx;
    logic [NCORES-1:0] rvalid, rvalid_nx;
    logic [AW-1:0]     sel_addr, ram_addr;
    logic [DW-1:0]     sel_din, ram_din;
    logic              sel_wr, ram_wren;
    logic [RD_LAT-1:0] tag_v;
    logic [IW-1:0]     tag_id [RD_LAT];

    function automatic logic [IW-1:0] inc(
        input logic [IW-1:0] v
    );
        return (int'(v) == NCORES - 1) ? '0 : IW'(int'(v) + 1);
    endfunction

    // First set bit of r at or after start, wrapping; MSB flags a hit.
    function automatic logic [IW:0] pick(
        input logic [NCORES-1:0] r,
        input logic [IW-1:0]     start
    );
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NCORES;
            if (r[idx]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    assign succ     = inc(owner);
    assign hit_idle = pick(bus.req, ptr);
    assign hit_rot  = pick(bus.req, succ);
    assign sel_addr = bus.addr[int'(owner)*AW +: AW];
    assign sel_din  = bus.wdata[int'(owner)*DW +: DW];
    assign sel_wr   = bus.wr[owner];

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        acc      = 1'b0;
        rot      = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit_idle[IW]) begin
                    state_nx = OWN;
                    owner_nx = hit_idle[IW-1:0];
                    cnt_nx   = '0;
                end
            end
            OWN: begin
                acc = bus.req[owner];
                rot = !acc || (cnt == CAP);
                if (acc && !rot) cnt_nx = cnt + 1'b1;
                // Owner is searched last, so a lone requester keeps it.
                if (rot) begin
                    if (hit_rot[IW]) begin
                        owner_nx = hit_rot[IW-1:0];
                        cnt_nx   = '0;
                        ptr_nx   = inc(hit_rot[IW-1:0]);
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        gnt_nx = '0;
        if (state_nx == OWN) gnt_nx[owner_nx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
            gnt   <= gnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wren <= 1'b0;
        end else begin
            ram_wren <= acc && sel_wr;
            if (acc) begin
                ram_addr <= sel_addr;
                ram_din  <= sel_din;
            end
        end
    end

    // Tag shift register lines rvalid up with ram_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            rvalid <= '0;
            for (int k = 0; k < RD_LAT; k++) tag_id[k] <= '0;
        end else begin
            tag_v[0]  <= acc && !sel_wr;
            tag_id[0] <= owner;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            rvalid <= rvalid_nx;
        end
    end

    always_comb begin
        rvalid_nx = '0;
        if (tag_v[RD_LAT-1]) rvalid_nx[tag_id[RD_LAT-1]] = 1'b1;
    end

    assign bus.gnt      = gnt;
    assign bus.rvalid   = rvalid;
    assign bus.rdata    = bus.ram_q;
    assign bus.ram_addr = ram_addr;
    assign bus.ram_din  = ram_din;
    assign bus.ram_wren = ram_wren;
endmodule
